// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register of a 5-stage MIPS pipeline.
// Fetches from an instruction memory over a req/ready handshake. The request
// is registered, so there is no combinational path from imem_ready to imem_req.
// The stage honours hazard-unit stalls and redirects on decode-resolved
// branches and jumps.
// Build option BRANCH_DELAY_SLOT_EN: when defined, the sequential word fetched
// after a taken branch/jump is kept as a valid delay slot. When undefined,
// that word is squashed into a bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_D,
  input  logic        pcsrc_D,
  input  logic        jump_D,
  input  logic [31:0] pcbranch_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pcplus4_D,
  output logic        valid_D
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit KEEP_WRONG_PATH = 1'b1;
`else
  localparam bit KEEP_WRONG_PATH = 1'b0;
`endif

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding or about to issue
    HOLD  = 2'd1,  // fetched word parked in the buffer while decode stalls
    DRAIN = 2'd2   // old-address request still in flight after a redirect
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;                  // address of the word being fetched
  logic [31:0] tgt_q, tgt_d;                // redirect target held during DRAIN
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pcplus4_q, buf_pcplus4_d;
  logic [31:0] buf_nextpc_q, buf_nextpc_d;  // where fetch resumes after HOLD

  logic        transfer;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        unused_pcbranch_lo;

  assign transfer = req_q & imem_ready;
  assign redirect = valid_q & ~stall_D & (pcsrc_D | jump_D);
  assign pc_plus4 = pc_q + 32'd4;
  // A taken branch outranks a jump when decode raises both.
  assign target   = pcsrc_D ? {pcbranch_D[31:2], 2'b00}
                            : {pcplus4_q[31:28], instr_q[25:0], 2'b00};
  assign unused_pcbranch_lo = ^pcbranch_D[1:0];

  assign imem_req  = req_q;
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign instr_D   = instr_q;
  assign pcplus4_D = pcplus4_q;
  assign valid_D   = valid_q;

  // Next-state, PC, request and IF/ID update for every FSM state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    req_d         = req_q;
    instr_d       = instr_q;
    pcplus4_d     = pcplus4_q;
    valid_d       = valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pcplus4_d = buf_pcplus4_q;
    buf_nextpc_d  = buf_nextpc_q;

    case (state_q)
      FETCH: begin
        req_d = 1'b1;
        if (transfer) begin
          if (redirect) begin
            // Word that arrived alongside the redirect is the wrong-path word.
            pc_d = target;
            if (KEEP_WRONG_PATH) begin
              instr_d   = imem_rdata;
              pcplus4_d = pc_plus4;
              valid_d   = 1'b1;
            end else begin
              instr_d = 32'h0;
              valid_d = 1'b0;
            end
          end else if (stall_D) begin
            // Decode cannot take the word yet: park it and drop the request.
            buf_instr_d   = imem_rdata;
            buf_pcplus4_d = pc_plus4;
            buf_nextpc_d  = pc_plus4;
            req_d         = 1'b0;
            state_d       = HOLD;
          end else begin
            instr_d   = imem_rdata;
            pcplus4_d = pc_plus4;
            valid_d   = 1'b1;
            pc_d      = pc_plus4;
          end
        end else begin
          if (!stall_D) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
          end
          if (redirect) begin
            if (req_q) begin
              // Keep imem_addr stable until the old request completes.
              tgt_d   = target;
              state_d = DRAIN;
            end else begin
              pc_d = target;
            end
          end
        end
      end

      HOLD: begin
        req_d = 1'b0;
        if (!stall_D) begin
          req_d   = 1'b1;
          state_d = FETCH;
          if (redirect) begin
            // Branch in decode resolved as the stall cleared: buffered word
            // is the wrong-path word.
            pc_d = target;
            if (KEEP_WRONG_PATH) begin
              instr_d   = buf_instr_q;
              pcplus4_d = buf_pcplus4_q;
              valid_d   = 1'b1;
            end else begin
              instr_d = 32'h0;
              valid_d = 1'b0;
            end
          end else begin
            instr_d   = buf_instr_q;
            pcplus4_d = buf_pcplus4_q;
            valid_d   = 1'b1;
            pc_d      = buf_nextpc_q;
          end
        end
      end

      DRAIN: begin
        req_d = 1'b1;
        if (transfer) begin
          // Old-address word returns; fetch moves to the target next cycle.
          pc_d    = tgt_q;
          state_d = FETCH;
          if (KEEP_WRONG_PATH) begin
            if (stall_D) begin
              buf_instr_d   = imem_rdata;
              buf_pcplus4_d = pc_plus4;
              buf_nextpc_d  = tgt_q;
              req_d         = 1'b0;
              state_d       = HOLD;
            end else begin
              instr_d   = imem_rdata;
              pcplus4_d = pc_plus4;
              valid_d   = 1'b1;
            end
          end else if (!stall_D) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
          end
        end else if (!stall_D) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset clears everything and points the PC at RESET_PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      tgt_q         <= 32'h0;
      req_q         <= 1'b0;
      instr_q       <= 32'h0;
      pcplus4_q     <= 32'h0;
      valid_q       <= 1'b0;
      buf_instr_q   <= 32'h0;
      buf_pcplus4_q <= 32'h0;
      buf_nextpc_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      tgt_q         <= tgt_d;
      req_q         <= req_d;
      instr_q       <= instr_d;
      pcplus4_q     <= pcplus4_d;
      valid_q       <= valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pcplus4_q <= buf_pcplus4_d;
      buf_nextpc_q  <= buf_nextpc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with a per-cycle scoreboard.
// Honours BRANCH_DELAY_SLOT_EN for the wrong-path expectations.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        stall_D;
  logic        pcsrc_D;
  logic        jump_D;
  logic [31:0] pcbranch_D;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_D;
  logic [31:0] pcplus4_D;
  logic        valid_D;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .stall_D(stall_D), .pcsrc_D(pcsrc_D),
    .jump_D(jump_D), .pcbranch_D(pcbranch_D), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_D(instr_D), .pcplus4_D(pcplus4_D), .valid_D(valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected right after its clock edge.
  typedef struct {
    logic        st;
    logic        ps;
    logic        jp;
    logic [31:0] br;
    logic        rdy;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        ev;
    logic [31:0] ea;
    logic        er;
  } step_t;

  step_t exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  // Memory image: bits [25:0] of the word at address a equal a[23:0], so the
  // word at 0x10 doubles as a jump to 0x40.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hE0, a[23:0]};
  endfunction

  function automatic step_t stp(input logic st, input logic ps, input logic jp,
                                input logic [31:0] br, input logic rdy,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic ev, input logic [31:0] ea,
                                input logic er);
    step_t s;
    s.st = st; s.ps = ps; s.jp = jp; s.br = br; s.rdy = rdy;
    s.ei = ei; s.ep = ep; s.ev = ev; s.ea = ea; s.er = er;
    return s;
  endfunction

  // Zero-wait sequential transfer of word k starting from address 0.
  function automatic step_t seq_step(input int k);
    logic [31:0] a;
    a = 32'(4 * k);
    return stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(a), a + 32'd4, 1'b1,
               a + 32'd4, 1'b1);
  endfunction

  // Drive one cycle; the memory answers with the word at the current address.
  task automatic apply_step(input step_t s);
    stall_D    = s.st;
    pcsrc_D    = s.ps;
    jump_D     = s.jp;
    pcbranch_D = s.br;
    imem_ready = s.rdy;
    imem_rdata = s.rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    exp_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    stall_D    = 1'b0;
    pcsrc_D    = 1'b0;
    jump_D     = 1'b0;
    pcbranch_D = 32'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    stall_D    = 1'b0;
    pcsrc_D    = 1'b0;
    jump_D     = 1'b0;
    pcbranch_D = 32'h0;
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({instr_D, pcplus4_D, valid_D, imem_req, imem_addr} !==
        {32'h0, 32'h0, 1'b0, 1'b0, RESET_PC}) begin
      err_cnt++;
      $display("FAIL reset_state: got instr=%h pc4=%h valid=%b req=%b addr=%h want 0/0/0/0/%h",
               instr_D, pcplus4_D, valid_D, imem_req, imem_addr, RESET_PC);
    end
    imem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vec_cnt++;
    if (imem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release_req: got %b want 0", imem_req);
    end
    @(posedge clk);
    #1;
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      err_cnt++;
      $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=%h",
               imem_req, imem_addr, RESET_PC);
    end
    $display("reset: first request addr=%h req=%b", imem_addr, imem_req);
  endtask

  task automatic test_sequential();
    step_t s[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 4; k++) s.push_back(seq_step(k));
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (instr_D !== e.ei || valid_D !== e.ev || (e.ev && pcplus4_D !== e.ep)) begin
        err_cnt++;
        $display("FAIL seq[%0d] ifid: got %h/%h/%b want %h/%h/%b",
                 i, instr_D, pcplus4_D, valid_D, e.ei, e.ep, e.ev);
      end
      vec_cnt++;
      if (imem_req !== e.er || imem_addr !== e.ea) begin
        err_cnt++;
        $display("FAIL seq[%0d] imem: got req=%b addr=%h want req=%b addr=%h",
                 i, imem_req, imem_addr, e.er, e.ea);
      end
      $display("seq[%0d] addr=%h instr_D=%h pcplus4_D=%h valid_D=%b",
               i, imem_addr, instr_D, pcplus4_D, valid_D);
    end
  endtask

  task automatic test_wait_states();
    step_t s[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 2; k++) s.push_back(seq_step(k));
    for (int k = 0; k < 3; k++)
      s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h8), 32'hC, 1'b1, 32'hC, 1'b1));
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (instr_D !== e.ei || valid_D !== e.ev || (e.ev && pcplus4_D !== e.ep)) begin
        err_cnt++;
        $display("FAIL wait[%0d] ifid: got %h/%h/%b want %h/%h/%b",
                 i, instr_D, pcplus4_D, valid_D, e.ei, e.ep, e.ev);
      end
      vec_cnt++;
      if (imem_req !== e.er || imem_addr !== e.ea) begin
        err_cnt++;
        $display("FAIL wait[%0d] imem: got req=%b addr=%h want req=%b addr=%h",
                 i, imem_req, imem_addr, e.er, e.ea);
      end
      $display("wait[%0d] addr=%h instr_D=%h pcplus4_D=%h valid_D=%b",
               i, imem_addr, instr_D, pcplus4_D, valid_D);
    end
  endtask

  task automatic test_stall();
    step_t s[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 3; k++) s.push_back(seq_step(k));
    s.push_back(stp(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h8), 32'hC, 1'b1, 32'hC, 1'b0));
    s.push_back(stp(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, mem_word(32'h8), 32'hC, 1'b1, 32'hC, 1'b0));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mem_word(32'hC), 32'h10, 1'b1, 32'h10, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h10), 32'h14, 1'b1, 32'h14, 1'b1));
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (instr_D !== e.ei || valid_D !== e.ev || (e.ev && pcplus4_D !== e.ep)) begin
        err_cnt++;
        $display("FAIL stall[%0d] ifid: got %h/%h/%b want %h/%h/%b",
                 i, instr_D, pcplus4_D, valid_D, e.ei, e.ep, e.ev);
      end
      vec_cnt++;
      if (imem_req !== e.er || imem_addr !== e.ea) begin
        err_cnt++;
        $display("FAIL stall[%0d] imem: got req=%b addr=%h want req=%b addr=%h",
                 i, imem_req, imem_addr, e.er, e.ea);
      end
      $display("stall[%0d] addr=%h req=%b instr_D=%h pcplus4_D=%h valid_D=%b",
               i, imem_addr, imem_req, instr_D, pcplus4_D, valid_D);
    end
  endtask

  // Branch and jump raised together: the branch target (0x40) must win over
  // the jump target (0x10) encoded in the word at 0x4.
  task automatic test_branch();
    step_t s[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 2; k++) s.push_back(seq_step(k));
    s.push_back(stp(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, DS ? mem_word(32'h8) : 32'h0,
                    32'hC, DS, 32'h40, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h40), 32'h44, 1'b1, 32'h44, 1'b1));
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (instr_D !== e.ei || valid_D !== e.ev || (e.ev && pcplus4_D !== e.ep)) begin
        err_cnt++;
        $display("FAIL branch[%0d] ifid: got %h/%h/%b want %h/%h/%b",
                 i, instr_D, pcplus4_D, valid_D, e.ei, e.ep, e.ev);
      end
      vec_cnt++;
      if (imem_req !== e.er || imem_addr !== e.ea) begin
        err_cnt++;
        $display("FAIL branch[%0d] imem: got req=%b addr=%h want req=%b addr=%h",
                 i, imem_req, imem_addr, e.er, e.ea);
      end
      $display("branch[%0d] addr=%h instr_D=%h pcplus4_D=%h valid_D=%b",
               i, imem_addr, instr_D, pcplus4_D, valid_D);
    end
  endtask

  task automatic test_jump_drain();
    step_t s[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 5; k++) s.push_back(seq_step(k));
    s.push_back(stp(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h14, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h14, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, DS ? mem_word(32'h14) : 32'h0,
                    32'h18, DS, 32'h40, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h40), 32'h44, 1'b1, 32'h44, 1'b1));
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (instr_D !== e.ei || valid_D !== e.ev || (e.ev && pcplus4_D !== e.ep)) begin
        err_cnt++;
        $display("FAIL jump[%0d] ifid: got %h/%h/%b want %h/%h/%b",
                 i, instr_D, pcplus4_D, valid_D, e.ei, e.ep, e.ev);
      end
      vec_cnt++;
      if (imem_req !== e.er || imem_addr !== e.ea) begin
        err_cnt++;
        $display("FAIL jump[%0d] imem: got req=%b addr=%h want req=%b addr=%h",
                 i, imem_req, imem_addr, e.er, e.ea);
      end
      $display("jump[%0d] addr=%h instr_D=%h pcplus4_D=%h valid_D=%b",
               i, imem_addr, instr_D, pcplus4_D, valid_D);
    end
  endtask

  // Branch held under stall is ignored, then taken once the stall clears
  // while the request is still waiting (DRAIN path).
  task automatic test_stall_branch();
    step_t s[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 2; k++) s.push_back(seq_step(k));
    s.push_back(stp(1'b1, 1'b1, 1'b0, 32'h80, 1'b0, mem_word(32'h4), 32'h8, 1'b1, 32'h8, 1'b1));
    s.push_back(stp(1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, DS ? mem_word(32'h8) : 32'h0,
                    32'hC, DS, 32'h80, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h80), 32'h84, 1'b1, 32'h84, 1'b1));
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (instr_D !== e.ei || valid_D !== e.ev || (e.ev && pcplus4_D !== e.ep)) begin
        err_cnt++;
        $display("FAIL stallbr[%0d] ifid: got %h/%h/%b want %h/%h/%b",
                 i, instr_D, pcplus4_D, valid_D, e.ei, e.ep, e.ev);
      end
      vec_cnt++;
      if (imem_req !== e.er || imem_addr !== e.ea) begin
        err_cnt++;
        $display("FAIL stallbr[%0d] imem: got req=%b addr=%h want req=%b addr=%h",
                 i, imem_req, imem_addr, e.er, e.ea);
      end
      $display("stallbr[%0d] addr=%h instr_D=%h pcplus4_D=%h valid_D=%b",
               i, imem_addr, instr_D, pcplus4_D, valid_D);
    end
  endtask

  // Branch to 0xFFFFFFFF (low bits forced off), then wrap to 0.
  task automatic test_wrap();
    step_t s[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 2; k++) s.push_back(seq_step(k));
    s.push_back(stp(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, DS ? mem_word(32'h8) : 32'h0,
                    32'hC, DS, 32'hFFFF_FFFC, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1,
                    32'h0, 1'b1));
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h0), 32'h4, 1'b1, 32'h4, 1'b1));
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (instr_D !== e.ei || valid_D !== e.ev || (e.ev && pcplus4_D !== e.ep)) begin
        err_cnt++;
        $display("FAIL wrap[%0d] ifid: got %h/%h/%b want %h/%h/%b",
                 i, instr_D, pcplus4_D, valid_D, e.ei, e.ep, e.ev);
      end
      vec_cnt++;
      if (imem_req !== e.er || imem_addr !== e.ea) begin
        err_cnt++;
        $display("FAIL wrap[%0d] imem: got req=%b addr=%h want req=%b addr=%h",
                 i, imem_req, imem_addr, e.er, e.ea);
      end
      $display("wrap[%0d] addr=%h instr_D=%h pcplus4_D=%h valid_D=%b",
               i, imem_addr, instr_D, pcplus4_D, valid_D);
    end
  endtask

  task automatic test_reset_mid_drain();
    step_t s[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 2; k++) s.push_back(seq_step(k));
    s.push_back(stp(1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8, 1'b1));
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (imem_req !== e.er || imem_addr !== e.ea || valid_D !== e.ev) begin
        err_cnt++;
        $display("FAIL rstdrain[%0d] pre: got req=%b addr=%h valid=%b want req=%b addr=%h valid=%b",
                 i, imem_req, imem_addr, valid_D, e.er, e.ea, e.ev);
      end
    end
    // Asynchronous reset in the middle of the drain.
    pcsrc_D = 1'b0;
    reset_n = 1'b0;
    #2;
    vec_cnt++;
    if ({instr_D, pcplus4_D, valid_D, imem_req, imem_addr} !==
        {32'h0, 32'h0, 1'b0, 1'b0, RESET_PC}) begin
      err_cnt++;
      $display("FAIL rstdrain async: got instr=%h pc4=%h valid=%b req=%b addr=%h",
               instr_D, pcplus4_D, valid_D, imem_req, imem_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    s.delete();
    s.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mem_word(RESET_PC), RESET_PC + 32'd4, 1'b1,
                    RESET_PC + 32'd4, 1'b1));
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      err_cnt++;
      $display("FAIL rstdrain first_req: got req=%b addr=%h want req=1 addr=%h",
               imem_req, imem_addr, RESET_PC);
    end
    foreach (s[i]) begin
      apply_step(s[i]);
      e = exp_q.pop_front();
      vec_cnt++;
      if (instr_D !== e.ei || valid_D !== e.ev || pcplus4_D !== e.ep || imem_addr !== e.ea) begin
        err_cnt++;
        $display("FAIL rstdrain post[%0d]: got %h/%h/%b addr=%h want %h/%h/%b addr=%h",
                 i, instr_D, pcplus4_D, valid_D, imem_addr, e.ei, e.ep, e.ev, e.ea);
      end
      $display("rstdrain[%0d] addr=%h instr_D=%h pcplus4_D=%h valid_D=%b",
               i, imem_addr, instr_D, pcplus4_D, valid_D);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall();
    test_branch();
    test_jump_drain();
    test_stall_branch();
    test_wrap();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
